// File: rtl/execute_cycle_if.sv
// Bundle of ID/EX inputs, forwarding controls and EX/MEM outputs for the execute stage.
interface execute_cycle_if #(
    parameter int XLEN = 32
);
    logic            RegWriteE;
    logic            ALUSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [4:0]      RD_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;

    // Upstream pipeline / hazard unit side.
    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE,
        output RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
        input  ALUResultM, WriteDataM, PCPlus4M
    );

    // Execute stage side.
    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUControlE,
        input  RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
        output ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    execute_cycle_if.slave bus
);
    // ALU: wrap-around add/sub, bitwise and/or, signed set-less-than; unused codes yield 0.
    function automatic logic [XLEN-1:0] aluOp(
        input logic [2:0]             ctrl,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        case (ctrl)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b101:  res = {{(XLEN-1){1'b0}}, (a < b)};
            default: res = '0;
        endcase
        return res;
    endfunction

    logic signed [XLEN-1:0] srcA;
    logic signed [XLEN-1:0] writeData;
    logic signed [XLEN-1:0] srcB;
    logic        [XLEN-1:0] aluResult;

    logic            regWrite_p1;
    logic            memWrite_p1;
    logic [1:0]      resultSrc_p1;
    logic [4:0]      rd_p1;
    logic [XLEN-1:0] aluResult_p1;
    logic [XLEN-1:0] writeData_p1;
    logic [XLEN-1:0] pcPlus4_p1;

    // Operand selection; the 10 path reads the pre-edge EX/MEM result, so no loop forms.
    always_comb begin
        srcA      = bus.RD1_E;
        writeData = bus.RD2_E;
        case (bus.ForwardAE)
            2'b01:   srcA = bus.ResultW;
            2'b10:   srcA = aluResult_p1;
            default: srcA = bus.RD1_E;
        endcase
        case (bus.ForwardBE)
            2'b01:   writeData = bus.ResultW;
            2'b10:   writeData = aluResult_p1;
            default: writeData = bus.RD2_E;
        endcase
        srcB      = bus.ALUSrcE ? bus.Imm_Ext_E : writeData;
        aluResult = aluOp(bus.ALUControlE, srcA, srcB);
    end

    // Branch decision and target are combinational and deliberately not reset-gated.
    assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & (aluResult == '0));
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    // ---- EX / MEM boundary ----
    // EX/MEM register; reset squashes the in-flight instruction and clears its data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regWrite_p1  <= 1'b0;
            memWrite_p1  <= 1'b0;
            resultSrc_p1 <= 2'b00;
            rd_p1        <= '0;
            aluResult_p1 <= '0;
            writeData_p1 <= '0;
            pcPlus4_p1   <= '0;
        end else begin
            regWrite_p1  <= bus.RegWriteE;
            memWrite_p1  <= bus.MemWriteE;
            resultSrc_p1 <= bus.ResultSrcE;
            rd_p1        <= bus.RD_E;
            aluResult_p1 <= aluResult;
            writeData_p1 <= writeData;
            pcPlus4_p1   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM  = regWrite_p1;
    assign bus.MemWriteM  = memWrite_p1;
    assign bus.ResultSrcM = resultSrc_p1;
    assign bus.RD_M       = rd_p1;
    assign bus.ALUResultM = aluResult_p1;
    assign bus.WriteDataM = writeData_p1;
    assign bus.PCPlus4M   = pcPlus4_p1;
endmodule

// File: tb/tb_execute_cycle.sv
// Table-driven bench for execute_cycle with a scoreboard for the registered outputs.
module tb_execute_cycle;
    logic clk;
    logic rst;

    execute_cycle_if ifc ();

    execute_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        rw;
        logic        aluSrc;
        logic        mw;
        logic        jump;
        logic        br;
        logic [1:0]  rs;
        logic [2:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] resW;
        logic        expPcSrc;
        logic [31:0] expTarget;
        logic [31:0] expAlu;
        logic [31:0] expWd;
    } vec_t;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } mexp_t;

    vec_t  vecs[$];
    mexp_t expQ[$];
    int    nChecks = 0;
    int    nFails  = 0;

    function automatic vec_t mk(
        input logic rs_t, input logic rw, input logic aluSrc, input logic mw,
        input logic jump, input logic br, input logic [1:0] rs, input logic [2:0] ctrl,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pc4,
        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resW,
        input logic expPcSrc, input logic [31:0] expTarget,
        input logic [31:0] expAlu, input logic [31:0] expWd
    );
        vec_t v;
        v.rst = rs_t; v.rw = rw; v.aluSrc = aluSrc; v.mw = mw; v.jump = jump; v.br = br;
        v.rs = rs; v.ctrl = ctrl; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rd = rd;
        v.pc = pc; v.pc4 = pc4; v.fa = fa; v.fb = fb; v.resW = resW;
        v.expPcSrc = expPcSrc; v.expTarget = expTarget; v.expAlu = expAlu; v.expWd = expWd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one instruction, check combinational outputs, then check its M-stage result.
    task automatic applyVec(input vec_t v);
        mexp_t e;
        mexp_t got;
        @(negedge clk);
        rst                 = v.rst;
        ifc.RegWriteE       = v.rw;
        ifc.ALUSrcE         = v.aluSrc;
        ifc.MemWriteE       = v.mw;
        ifc.JumpE           = v.jump;
        ifc.BranchE         = v.br;
        ifc.ResultSrcE      = v.rs;
        ifc.ALUControlE     = v.ctrl;
        ifc.RD1_E           = v.rd1;
        ifc.RD2_E           = v.rd2;
        ifc.Imm_Ext_E       = v.imm;
        ifc.RD_E            = v.rd;
        ifc.PCE             = v.pc;
        ifc.PCPlus4E        = v.pc4;
        ifc.ForwardAE       = v.fa;
        ifc.ForwardBE       = v.fb;
        ifc.ResultW         = v.resW;
        #1;
        check("PCSrcE", {31'b0, ifc.PCSrcE}, {31'b0, v.expPcSrc});
        check("PCTargetE", ifc.PCTargetE, v.expTarget);
        e.rw  = v.rst ? v.rw  : 1'b0;
        e.mw  = v.rst ? v.mw  : 1'b0;
        e.rs  = v.rst ? v.rs  : 2'b00;
        e.rd  = v.rst ? v.rd  : 5'd0;
        e.alu = v.rst ? v.expAlu : 32'd0;
        e.wd  = v.rst ? v.expWd  : 32'd0;
        e.pc4 = v.rst ? v.pc4 : 32'd0;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            got = expQ.pop_front();
            check("RegWriteM", {31'b0, ifc.RegWriteM}, {31'b0, got.rw});
            check("MemWriteM", {31'b0, ifc.MemWriteM}, {31'b0, got.mw});
            check("ResultSrcM", {30'b0, ifc.ResultSrcM}, {30'b0, got.rs});
            check("RD_M", {27'b0, ifc.RD_M}, {27'b0, got.rd});
            check("ALUResultM", ifc.ALUResultM, got.alu);
            check("WriteDataM", ifc.WriteDataM, got.wd);
            check("PCPlus4M", ifc.PCPlus4M, got.pc4);
        end
    endtask

    initial begin
        int acc;
        rst = 1'b0;
        ifc.RegWriteE = 0; ifc.ALUSrcE = 0; ifc.MemWriteE = 0; ifc.JumpE = 0; ifc.BranchE = 0;
        ifc.ResultSrcE = 0; ifc.ALUControlE = 0; ifc.RD1_E = 0; ifc.RD2_E = 0;
        ifc.Imm_Ext_E = 0; ifc.RD_E = 0; ifc.PCE = 0; ifc.PCPlus4E = 0;
        ifc.ForwardAE = 0; ifc.ForwardBE = 0; ifc.ResultW = 0;

        //             rst rw src mw jmp br rs     ctrl    rd1           rd2        imm           rd     pc            pc4        fa     fb     resW      pcs target        alu           wd
        // reset held with live inputs; PCSrcE still follows the E inputs
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 2'b01, 3'b000, 32'd5,        32'd3,     32'h10,       5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    1, 32'h210,      32'd0,        32'd0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 2'b01, 3'b000, 32'd5,        32'd3,     32'h10,       5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h210,      32'd0,        32'd0));
        // add / sub / wrap
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 32'd5,        32'd3,     32'h10,       5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h210,      32'd8,        32'd3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b001, 32'd5,        32'd3,     32'h10,       5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h210,      32'd2,        32'd3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b001, 32'd0,        32'd1,     32'h10,       5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h210,      32'hFFFFFFFF, 32'd1));
        // signed slt with immediate, both orders
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b101, 32'hFFFFFFFF, 32'd0,     32'd1,        5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h201,      32'd1,        32'd0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b101, 32'd1,        32'd0,     32'hFFFFFFFF, 5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h1FF,      32'd0,        32'd0));
        // and / or / unused opcode (zero result makes beq taken)
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b010, 32'hF0F0,     32'hFF00,  32'd0,        5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h200,      32'hF000,     32'hFF00));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b011, 32'hF0F0,     32'hFF00,  32'd0,        5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h200,      32'hFFF0,     32'hFF00));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2'b00, 3'b100, 32'd7,        32'd7,     32'd0,        5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    1, 32'h200,      32'd0,        32'd7));
        // forwarding: EX/MEM result into A, ResultW into B, EX/MEM into B, code 11 as 00
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 32'd10,       32'd20,    32'd0,        5'd3,  32'h200,      32'h204,   2'b00, 2'b00, 32'd0,    0, 32'h200,      32'd30,       32'd20));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b000, 32'd0,        32'd0,     32'd4,        5'd3,  32'h200,      32'h204,   2'b10, 2'b00, 32'd0,    0, 32'h204,      32'd34,       32'd0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 2'b00, 3'b000, 32'd1,        32'd0,     32'd2,        5'd3,  32'h200,      32'h204,   2'b00, 2'b01, 32'd7,    0, 32'h202,      32'd3,        32'd7));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 32'd1,        32'd99,    32'd0,        5'd3,  32'h200,      32'h204,   2'b11, 2'b10, 32'h55,   0, 32'h200,      32'd4,        32'd3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b001, 32'd4,        32'd6,     32'd0,        5'd3,  32'h200,      32'h204,   2'b00, 2'b11, 32'h77,   0, 32'h200,      32'hFFFFFFFE, 32'd6));
        // beq taken / not taken, jal always taken, target wrap
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2'b00, 3'b001, 32'd9,        32'd9,     32'h20,       5'd0,  32'h100,      32'h104,   2'b00, 2'b00, 32'd0,    1, 32'h120,      32'd0,        32'd9));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2'b00, 3'b001, 32'd9,        32'd8,     32'h20,       5'd0,  32'h100,      32'h104,   2'b00, 2'b00, 32'd0,    0, 32'h120,      32'd1,        32'd8));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 2'b00, 3'b001, 32'd3,        32'd8,     32'h20,       5'd1,  32'h100,      32'h104,   2'b00, 2'b00, 32'd0,    1, 32'h120,      32'hFFFFFFFB, 32'd8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 32'd0,        32'd0,     32'h20,       5'd0,  32'hFFFFFFF0, 32'hFFFFFFF4, 2'b00, 2'b00, 32'd0, 0, 32'h10,      32'd0,        32'd0));
        // pass-through, then reset squashes the next instruction
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b10, 3'b000, 32'd1,        32'd1,     32'd0,        5'd17, 32'h40,       32'h44,    2'b00, 2'b00, 32'd0,    0, 32'h40,       32'd2,        32'd1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2'b10, 3'b000, 32'd1,        32'd1,     32'd0,        5'd17, 32'h40,       32'h44,    2'b00, 2'b00, 32'd0,    0, 32'h40,       32'd0,        32'd0));
        // after reset the forwarded EX/MEM result is the cleared zero
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 32'd123,      32'd0,     32'd5,        5'd0,  32'h0,        32'h4,     2'b10, 2'b00, 32'd0,    0, 32'h5,        32'd5,        32'd0));

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i]);

        // Back-to-back dependent adds chained through the EX/MEM forwarding path.
        applyVec(mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b000, 32'd100, 32'd0, 32'd0, 5'd4, 32'h0, 32'h4, 2'b00, 2'b00, 32'd0, 0, 32'h0, 32'd100, 32'd0));
        acc = 100;
        for (int k = 1; k <= 5; k++) begin
            acc = acc + k * 3;
            applyVec(mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b000, 32'd0, k, k * 3, 5'd4, 32'h0, 32'h4,
                        2'b10, 2'b00, 32'd0, 0, k * 3, acc, k));
        end

        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL scoreboard drain: got %0d leftover entries, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
